// File: rtl/anubis_status_sequencer_if.sv
// Handshake between the Anubis engine and the status sequencer, plus the control word
// and status outputs that go to the display/speaker controller.
interface anubis_status_sequencer_if;
  logic        op_start;
  logic        op_done;
  logic        op_pass;
  logic        busy;
  logic        ack;
  logic [15:0] ctrl_word;
  logic [1:0]  status;
  logic        beep;

  modport master (
    output op_start, op_done, op_pass,
    input  busy, ack, ctrl_word, status, beep
  );

  modport slave (
    input  op_start, op_done, op_pass,
    output busy, ack, ctrl_word, status, beep
  );
endinterface

// File: rtl/anubis_status_sequencer.sv
// Times the SAFE/BUSY/PASS/FAIL status phases in ms ticks and drives the one-hot
// control word, status code and fail beep. All outputs are registered.
module anubis_status_sequencer #(
  parameter int unsigned TICK_DIV  = 100_000,
  parameter int unsigned SAFE_MS   = 500,
  parameter int unsigned RESULT_MS = 3000,
  parameter int unsigned BEEP_MS   = 250
) (
  input logic                      clk,
  input logic                      rst,
  anubis_status_sequencer_if.slave bus
);

  localparam int unsigned MsMax  = (SAFE_MS > RESULT_MS) ? SAFE_MS : RESULT_MS;
  localparam int unsigned MsW    = $clog2(MsMax + 1);
  localparam int unsigned PreW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned BeepW  = (BEEP_MS > 1) ? $clog2(BEEP_MS) : 1;

  typedef enum logic [2:0] {StIdle, StSafe, StBusy, StPass, StFail} state_e;

  state_e             state_q, state_d;
  logic [PreW-1:0]    pre_q, pre_d;
  logic [MsW-1:0]     ms_q, ms_d;
  logic [BeepW-1:0]   bcnt_q, bcnt_d;
  logic               bph_q, bph_d;
  logic               pend_v_q, pend_v_d;
  logic               pend_p_q, pend_p_d;
  logic               ack_q, ack_d;
  logic               busy_q, busy_d;
  logic [15:0]        ctrl_q, ctrl_d;
  logic [1:0]         status_q, status_d;
  logic               beep_q, beep_d;
  logic               tick;
  logic               done_v;
  logic               done_p;

  assign tick = (pre_q == PreW'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      pre_q    <= '0;
      ms_q     <= '0;
      bcnt_q   <= '0;
      bph_q    <= 1'b0;
      pend_v_q <= 1'b0;
      pend_p_q <= 1'b0;
      ack_q    <= 1'b0;
      busy_q   <= 1'b0;
      ctrl_q   <= '0;
      status_q <= '0;
      beep_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pre_q    <= pre_d;
      ms_q     <= ms_d;
      bcnt_q   <= bcnt_d;
      bph_q    <= bph_d;
      pend_v_q <= pend_v_d;
      pend_p_q <= pend_p_d;
      ack_q    <= ack_d;
      busy_q   <= busy_d;
      ctrl_q   <= ctrl_d;
      status_q <= status_d;
      beep_q   <= beep_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pend_v_d = pend_v_q;
    pend_p_d = pend_p_q;
    ack_d    = 1'b0;
    // A done arriving on the SAFE exit cycle still counts as the pending result.
    done_v   = pend_v_q | bus.op_done;
    done_p   = bus.op_done ? bus.op_pass : pend_p_q;

    case (state_q)
      StIdle: begin
        pend_v_d = 1'b0;
        if (bus.op_start) begin
          state_d  = StSafe;
          pend_v_d = bus.op_done;
          pend_p_d = bus.op_done ? bus.op_pass : pend_p_q;
        end
      end
      StSafe: begin
        pend_v_d = done_v;
        pend_p_d = done_p;
        if (tick && ms_q == MsW'(SAFE_MS - 1)) begin
          pend_v_d = 1'b0;
          if (done_v) begin
            state_d = done_p ? StPass : StFail;
            ack_d   = 1'b1;
          end else begin
            state_d = StBusy;
          end
        end
      end
      StBusy: begin
        if (bus.op_done) begin
          state_d = bus.op_pass ? StPass : StFail;
          ack_d   = 1'b1;
        end
      end
      StPass, StFail: begin
        if (tick && ms_q == MsW'(RESULT_MS - 1)) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Timebase restarts on every state entry so each phase is exactly N ms long.
    if (state_d != state_q) begin
      pre_d  = '0;
      ms_d   = '0;
      bcnt_d = '0;
      bph_d  = 1'b0;
    end else begin
      pre_d  = tick ? '0 : pre_q + 1'b1;
      ms_d   = ms_q;
      bcnt_d = bcnt_q;
      bph_d  = bph_q;
      if (tick) begin
        if (ms_q != MsW'(MsMax)) ms_d = ms_q + 1'b1;
        if (bcnt_q == BeepW'(BEEP_MS - 1)) begin
          bcnt_d = '0;
          bph_d  = ~bph_q;
        end else begin
          bcnt_d = bcnt_q + 1'b1;
        end
      end
    end
  end

  // Outputs are decoded from the next state so they change on the same edge as state_q.
  always_comb begin
    busy_d   = 1'b0;
    ctrl_d   = 16'h0000;
    status_d = 2'b00;
    beep_d   = 1'b0;
    case (state_d)
      StSafe: begin
        busy_d = 1'b1;
        ctrl_d = 16'h0001;
      end
      StBusy: begin
        busy_d   = 1'b1;
        ctrl_d   = 16'h0002;
        status_d = 2'b01;
      end
      StPass: begin
        ctrl_d   = 16'h0004;
        status_d = 2'b10;
      end
      StFail: begin
        ctrl_d   = 16'h0008;
        status_d = 2'b11;
        beep_d   = ~bph_d;
      end
      default: ;
    endcase
  end

  assign bus.busy      = busy_q;
  assign bus.ack       = ack_q;
  assign bus.ctrl_word = ctrl_q;
  assign bus.status    = status_q;
  assign bus.beep      = beep_q;

endmodule

// File: doc/anubis_status_sequencer.md
Name: anubis_status_sequencer

Overview:
Producer side of the 16-bit control word consumed by the seven-segment/speaker controller. It takes the Anubis engine's start/done/pass handshake and times each status phase in milliseconds: SAFE, then BUSY, then PASS or FAIL. For each phase it drives a one-hot control word and a 2-bit status code, and it acknowledges each result to the engine. It sits between the Anubis core and the display/speaker controller and replaces the board switches as the command source.

Parameters:
TICK_DIV, 100_000, clk cycles per 1 ms tick (100 MHz board clock)
SAFE_MS, 500, dwell in SAFE phase, ms
RESULT_MS, 3000, dwell in PASS/FAIL phase, ms
BEEP_MS, 250, FAIL beep half-period, ms

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
op_start  in  1  1-cycle pulse: Anubis operation begins
op_done  in  1  1-cycle pulse: Anubis operation finished
op_pass  in  1  result flag, sampled only when op_done=1 (1=pass, 0=fail)
busy  out  1  high while an operation is in progress (SAFE or BUSY phase)
ack  out  1  1-cycle pulse: result accepted
ctrl_word  out  16  one-hot command to display/speaker controller
status  out  2  00 idle/safe, 01 busy, 10 pass, 11 fail
beep  out  1  speaker gate, active only in FAIL phase

Behaviour:
- Reset (async, any time, including mid-phase): state=IDLE, prescaler=0, ms=0, pend_v=0, pend_p=0, busy=0, ack=0, ctrl_word=16'h0000, status=00, beep=0.
- All outputs are registered. They update on the same edge as the state register.
- Tick generation:
  - Prescaler counts 0..TICK_DIV-1 and wraps.
  - tick=1 when prescaler==TICK_DIV-1.
  - ms increments on each tick.
  - Prescaler and ms clear on every state entry.
  - A timed state of N ms therefore lasts exactly N*TICK_DIV cycles.
- State IDLE:
  - ctrl_word=0, status=00, busy=0.
  - op_start -> SAFE.
  - op_done in IDLE without op_start is ignored.
- State SAFE:
  - ctrl_word=16'h0001, status=00, busy=1.
  - op_done here sets pend_v=1 and pend_p=op_pass.
  - When ms reaches SAFE_MS:
    - pend_v=0 -> BUSY.
    - pend_v=1 -> PASS or FAIL per pend_p; ack pulses on the transition edge; pend_v clears.
- State BUSY:
  - ctrl_word=16'h0002, status=01, busy=1. Untimed.
  - op_done -> PASS (op_pass=1) or FAIL (op_pass=0), with ack=1 for exactly one cycle on that edge.
- State PASS:
  - ctrl_word=16'h0004, status=10, busy=0, beep=0.
  - When ms reaches RESULT_MS -> IDLE.
- State FAIL:
  - ctrl_word=16'h0008, status=11, busy=0.
  - beep=1 while (ms / BEEP_MS) is even, 0 otherwise; beep starts at 1 on entry.
  - When ms reaches RESULT_MS -> IDLE; beep=0 in IDLE.
- Simultaneous events:
  - op_start with op_done in IDLE: enter SAFE and capture the done as pending.
  - op_start in any non-IDLE state is ignored; no restart.
  - A second op_done while pend_v=1 overwrites pend_p (last result wins).
- ms counter width is sized for max(SAFE_MS, RESULT_MS). The counter saturates and never wraps within a state.
- ctrl_word is always one-hot or zero, never multi-hot.

Test Plan:
Simulation parameters: TICK_DIV=10, SAFE_MS=5, RESULT_MS=20, BEEP_MS=4.
1. Reset and idle: assert rst mid-run in BUSY -> all outputs 0 immediately (asynchronously); after release, ctrl_word=0x0000 and status=00 with stimulus idle.
2. Pass flow: op_start at t0 -> ctrl_word=0x0001 for exactly 50 cycles, then 0x0002 with busy=1. op_done=1, op_pass=1 -> ack high for 1 cycle, ctrl_word=0x0004, status=10 for exactly 200 cycles, then 0x0000.
3. Fail flow: same as scenario 2 but op_pass=0 -> ctrl_word=0x0008, status=11. beep is high for 40 cycles, low for 40 cycles, repeating across 200 cycles, then 0.
4. Early done: op_done(pass=1) 20 cycles after op_start -> SAFE held the full 50 cycles, BUSY skipped, ack on the SAFE exit edge, ctrl_word goes 0x0001 -> 0x0004.
5. Simultaneous and ignored events: op_start+op_done(pass=0) in the same cycle in IDLE -> SAFE for 50 cycles, then FAIL. op_start during PASS -> no effect, PASS completes its 200 cycles.
6. Stray done: op_done in IDLE -> no ack, state stays IDLE, ctrl_word stays 0x0000.
